// File: rtl/coreriscv_axi4_release_pkg.sv
// Shared definitions for the release-channel demultiplexer.
// Holds the field widths, the default beat count, the r_type codes that
// carry data, a packed struct for the non-data fields of a beat and the
// has_data classifier used by the lock logic.
package coreriscv_axi4_release_pkg;

    localparam int unsigned HDR_W         = 2;
    localparam int unsigned ADDR_BEAT_W   = 3;
    localparam int unsigned ADDR_BLOCK_W  = 26;
    localparam int unsigned XACT_ID_W     = 1;
    localparam int unsigned R_TYPE_W      = 3;
    localparam int unsigned BEATS_DEFAULT = 8;
    localparam int unsigned NUM_PORTS     = 4;

    localparam logic [R_TYPE_W-1:0] RT_INVALIDATE_DATA = 3'd0;
    localparam logic [R_TYPE_W-1:0] RT_DOWNGRADE_DATA  = 3'd1;
    localparam logic [R_TYPE_W-1:0] RT_COPY_DATA       = 3'd2;

    typedef struct packed {
        logic [HDR_W-1:0]        header_src;
        logic [HDR_W-1:0]        header_dst;
        logic [ADDR_BEAT_W-1:0]  addr_beat;
        logic [ADDR_BLOCK_W-1:0] addr_block;
        logic [XACT_ID_W-1:0]    client_xact_id;
        logic                    voluntary;
        logic [R_TYPE_W-1:0]     r_type;
    } release_meta_t;

    localparam int unsigned META_W = $bits(release_meta_t);

    function automatic logic has_data(input logic [R_TYPE_W-1:0] r_type);
        return (r_type == RT_INVALIDATE_DATA) || (r_type == RT_DOWNGRADE_DATA) ||
               (r_type == RT_COPY_DATA);
    endfunction

endpackage

// File: rtl/coreriscv_axi4_release_buf.sv
// Single-entry beat buffer for the release demultiplexer.
// Ports:
//   clk, reset_n  - clock and asynchronous active-low reset
//   i_push        - load i_bits / i_dst (wins over i_pop, giving replace-in-place)
//   i_pop         - release the held entry
//   i_bits, i_dst - beat contents and its resolved output port
//   o_full        - entry valid
//   o_bits, o_dst - held beat and its output port
module coreriscv_axi4_release_buf
    import coreriscv_axi4_release_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [W-1:0]     i_bits,
    input  logic [HDR_W-1:0] i_dst,
    output logic             o_full,
    output logic [W-1:0]     o_bits,
    output logic [HDR_W-1:0] o_dst
);

    logic             r_full;
    logic [W-1:0]     r_bits;
    logic [HDR_W-1:0] r_dst;

    // The parent only pushes when empty or popping, so a push never loses a beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= 1'b0;
            r_bits <= '0;
            r_dst  <= '0;
        end else if (i_push) begin
            r_full <= 1'b1;
            r_bits <= i_bits;
            r_dst  <= i_dst;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_bits = r_bits;
    assign o_dst  = r_dst;

endmodule

// File: rtl/coreriscv_axi4_release_demux.sv
// Release-channel demultiplexer: routes each beat to one of four outputs.
// A data-carrying first beat locks the route for BEATS beats so a whole
// message follows its first beat's destination.
// Ports:
//   clk, reset_n            - clock and asynchronous active-low reset
//   io_in_*                 - upstream valid/ready beat with header and payload
//   io_out_k_* (k = 0..3)   - per-destination valid/ready; bits are shared
//   io_locked               - multi-beat lock in progress
//   io_dst_err              - sticky: locked beat arrived with a different header_dst
// Optional feature: define CORERISCV_AXI4_DEMUX_CHECK_EN to build the io_dst_err
// checker; otherwise io_dst_err is tied low.
module coreriscv_axi4_release_demux
    import coreriscv_axi4_release_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned BEATS  = BEATS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    io_in_valid,
    output logic                    io_in_ready,
    input  logic [HDR_W-1:0]        io_in_bits_header_src,
    input  logic [HDR_W-1:0]        io_in_bits_header_dst,
    input  logic [ADDR_BEAT_W-1:0]  io_in_bits_payload_addr_beat,
    input  logic [ADDR_BLOCK_W-1:0] io_in_bits_payload_addr_block,
    input  logic [XACT_ID_W-1:0]    io_in_bits_payload_client_xact_id,
    input  logic                    io_in_bits_payload_voluntary,
    input  logic [R_TYPE_W-1:0]     io_in_bits_payload_r_type,
    input  logic [DATA_W-1:0]       io_in_bits_payload_data,
    output logic                    io_out_0_valid,
    input  logic                    io_out_0_ready,
    output logic [HDR_W-1:0]        io_out_0_bits_header_src,
    output logic [HDR_W-1:0]        io_out_0_bits_header_dst,
    output logic [ADDR_BEAT_W-1:0]  io_out_0_bits_payload_addr_beat,
    output logic [ADDR_BLOCK_W-1:0] io_out_0_bits_payload_addr_block,
    output logic [XACT_ID_W-1:0]    io_out_0_bits_payload_client_xact_id,
    output logic                    io_out_0_bits_payload_voluntary,
    output logic [R_TYPE_W-1:0]     io_out_0_bits_payload_r_type,
    output logic [DATA_W-1:0]       io_out_0_bits_payload_data,
    output logic                    io_out_1_valid,
    input  logic                    io_out_1_ready,
    output logic [HDR_W-1:0]        io_out_1_bits_header_src,
    output logic [HDR_W-1:0]        io_out_1_bits_header_dst,
    output logic [ADDR_BEAT_W-1:0]  io_out_1_bits_payload_addr_beat,
    output logic [ADDR_BLOCK_W-1:0] io_out_1_bits_payload_addr_block,
    output logic [XACT_ID_W-1:0]    io_out_1_bits_payload_client_xact_id,
    output logic                    io_out_1_bits_payload_voluntary,
    output logic [R_TYPE_W-1:0]     io_out_1_bits_payload_r_type,
    output logic [DATA_W-1:0]       io_out_1_bits_payload_data,
    output logic                    io_out_2_valid,
    input  logic                    io_out_2_ready,
    output logic [HDR_W-1:0]        io_out_2_bits_header_src,
    output logic [HDR_W-1:0]        io_out_2_bits_header_dst,
    output logic [ADDR_BEAT_W-1:0]  io_out_2_bits_payload_addr_beat,
    output logic [ADDR_BLOCK_W-1:0] io_out_2_bits_payload_addr_block,
    output logic [XACT_ID_W-1:0]    io_out_2_bits_payload_client_xact_id,
    output logic                    io_out_2_bits_payload_voluntary,
    output logic [R_TYPE_W-1:0]     io_out_2_bits_payload_r_type,
    output logic [DATA_W-1:0]       io_out_2_bits_payload_data,
    output logic                    io_out_3_valid,
    input  logic                    io_out_3_ready,
    output logic [HDR_W-1:0]        io_out_3_bits_header_src,
    output logic [HDR_W-1:0]        io_out_3_bits_header_dst,
    output logic [ADDR_BEAT_W-1:0]  io_out_3_bits_payload_addr_beat,
    output logic [ADDR_BLOCK_W-1:0] io_out_3_bits_payload_addr_block,
    output logic [XACT_ID_W-1:0]    io_out_3_bits_payload_client_xact_id,
    output logic                    io_out_3_bits_payload_voluntary,
    output logic [R_TYPE_W-1:0]     io_out_3_bits_payload_r_type,
    output logic [DATA_W-1:0]       io_out_3_bits_payload_data,
    output logic                    io_locked,
    output logic                    io_dst_err
);

    localparam int unsigned CNT_W  = $clog2(BEATS);
    localparam int unsigned BITS_W = META_W + DATA_W;

    release_meta_t          w_in_meta;
    release_meta_t          w_out_meta;
    logic [DATA_W-1:0]      w_out_data;
    logic [BITS_W-1:0]      w_buf_bits;
    logic [HDR_W-1:0]       w_buf_dst;
    logic                   w_full;
    logic [NUM_PORTS-1:0]   w_out_ready;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_locked;
    logic [HDR_W-1:0]       w_route;

    logic [CNT_W-1:0]       r_count;
    logic [HDR_W-1:0]       r_lock_dst;

    assign w_in_meta = '{
        header_src:     io_in_bits_header_src,
        header_dst:     io_in_bits_header_dst,
        addr_beat:      io_in_bits_payload_addr_beat,
        addr_block:     io_in_bits_payload_addr_block,
        client_xact_id: io_in_bits_payload_client_xact_id,
        voluntary:      io_in_bits_payload_voluntary,
        r_type:         io_in_bits_payload_r_type
    };

    assign w_out_ready = {io_out_3_ready, io_out_2_ready, io_out_1_ready, io_out_0_ready};
    // Only the ready of the port the held beat is routed to matters.
    assign w_pop       = w_full & w_out_ready[w_buf_dst];
    assign io_in_ready = ~w_full | w_pop;
    assign w_push      = io_in_valid & io_in_ready;
    assign w_locked    = (r_count != '0);
    assign w_route     = w_locked ? r_lock_dst : io_in_bits_header_dst;
    assign io_locked   = w_locked;

    coreriscv_axi4_release_buf #(
        .W (BITS_W)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_bits  ({w_in_meta, io_in_bits_payload_data}),
        .i_dst   (w_route),
        .o_full  (w_full),
        .o_bits  (w_buf_bits),
        .o_dst   (w_buf_dst)
    );

    // BEATS is a power of two, so the counter wraps to 0 after the last beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_lock_dst <= '0;
        end else if (w_push) begin
            if (w_locked) begin
                r_count <= r_count + CNT_W'(1);
            end else if (has_data(io_in_bits_payload_r_type)) begin
                r_count    <= CNT_W'(1);
                r_lock_dst <= io_in_bits_header_dst;
            end
        end
    end

`ifdef CORERISCV_AXI4_DEMUX_CHECK_EN
    logic r_dst_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dst_err <= 1'b0;
        end else if (w_push && w_locked && (io_in_bits_header_dst != r_lock_dst)) begin
            r_dst_err <= 1'b1;
        end
    end

    assign io_dst_err = r_dst_err;
`else
    assign io_dst_err = 1'b0;
`endif

    assign {w_out_meta, w_out_data} = w_buf_bits;

    assign io_out_0_valid = w_full & (w_buf_dst == 2'd0);
    assign io_out_1_valid = w_full & (w_buf_dst == 2'd1);
    assign io_out_2_valid = w_full & (w_buf_dst == 2'd2);
    assign io_out_3_valid = w_full & (w_buf_dst == 2'd3);

    assign io_out_0_bits_header_src             = w_out_meta.header_src;
    assign io_out_0_bits_header_dst             = w_out_meta.header_dst;
    assign io_out_0_bits_payload_addr_beat      = w_out_meta.addr_beat;
    assign io_out_0_bits_payload_addr_block     = w_out_meta.addr_block;
    assign io_out_0_bits_payload_client_xact_id = w_out_meta.client_xact_id;
    assign io_out_0_bits_payload_voluntary      = w_out_meta.voluntary;
    assign io_out_0_bits_payload_r_type         = w_out_meta.r_type;
    assign io_out_0_bits_payload_data           = w_out_data;

    assign io_out_1_bits_header_src             = w_out_meta.header_src;
    assign io_out_1_bits_header_dst             = w_out_meta.header_dst;
    assign io_out_1_bits_payload_addr_beat      = w_out_meta.addr_beat;
    assign io_out_1_bits_payload_addr_block     = w_out_meta.addr_block;
    assign io_out_1_bits_payload_client_xact_id = w_out_meta.client_xact_id;
    assign io_out_1_bits_payload_voluntary      = w_out_meta.voluntary;
    assign io_out_1_bits_payload_r_type         = w_out_meta.r_type;
    assign io_out_1_bits_payload_data           = w_out_data;

    assign io_out_2_bits_header_src             = w_out_meta.header_src;
    assign io_out_2_bits_header_dst             = w_out_meta.header_dst;
    assign io_out_2_bits_payload_addr_beat      = w_out_meta.addr_beat;
    assign io_out_2_bits_payload_addr_block     = w_out_meta.addr_block;
    assign io_out_2_bits_payload_client_xact_id = w_out_meta.client_xact_id;
    assign io_out_2_bits_payload_voluntary      = w_out_meta.voluntary;
    assign io_out_2_bits_payload_r_type         = w_out_meta.r_type;
    assign io_out_2_bits_payload_data           = w_out_data;

    assign io_out_3_bits_header_src             = w_out_meta.header_src;
    assign io_out_3_bits_header_dst             = w_out_meta.header_dst;
    assign io_out_3_bits_payload_addr_beat      = w_out_meta.addr_beat;
    assign io_out_3_bits_payload_addr_block     = w_out_meta.addr_block;
    assign io_out_3_bits_payload_client_xact_id = w_out_meta.client_xact_id;
    assign io_out_3_bits_payload_voluntary      = w_out_meta.voluntary;
    assign io_out_3_bits_payload_r_type         = w_out_meta.r_type;
    assign io_out_3_bits_payload_data           = w_out_data;

endmodule

// File: tb/tb_coreriscv_axi4_release_demux.sv
// Self-checking bench for coreriscv_axi4_release_demux: directed message
// scenarios followed by random traffic, checked by a scoreboard monitor
// against a message-level routing model.
module tb_coreriscv_axi4_release_demux;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned BEATS  = 8;
    localparam int unsigned BW     = 38 + DATA_W;
`ifdef CORERISCV_AXI4_DEMUX_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_src, in_dst;
    logic [2:0]        in_beat;
    logic [25:0]       in_block;
    logic              in_xid, in_vol;
    logic [2:0]        in_rtype;
    logic [DATA_W-1:0] in_data;
    logic [3:0]        rdy;
    logic [3:0]        out_valid;
    logic [1:0]        o_src [4];
    logic [1:0]        o_dst [4];
    logic [2:0]        o_beat [4];
    logic [25:0]       o_block [4];
    logic              o_xid [4];
    logic              o_vol [4];
    logic [2:0]        o_rtype [4];
    logic [DATA_W-1:0] o_data [4];
    logic              locked, dst_err;
    logic [BW-1:0]     in_bits;
    logic [BW-1:0]     o_bits [4];

    assign in_bits = {in_src, in_dst, in_beat, in_block, in_xid, in_vol, in_rtype, in_data};
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            o_bits[k] = {o_src[k], o_dst[k], o_beat[k], o_block[k], o_xid[k], o_vol[k],
                         o_rtype[k], o_data[k]};
        end
    end

    coreriscv_axi4_release_demux #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS)
    ) dut (
        .clk                                  (clk),
        .reset_n                              (reset_n),
        .io_in_valid                          (in_valid),
        .io_in_ready                          (in_ready),
        .io_in_bits_header_src                (in_src),
        .io_in_bits_header_dst                (in_dst),
        .io_in_bits_payload_addr_beat         (in_beat),
        .io_in_bits_payload_addr_block        (in_block),
        .io_in_bits_payload_client_xact_id    (in_xid),
        .io_in_bits_payload_voluntary         (in_vol),
        .io_in_bits_payload_r_type            (in_rtype),
        .io_in_bits_payload_data              (in_data),
        .io_out_0_valid                       (out_valid[0]),
        .io_out_0_ready                       (rdy[0]),
        .io_out_0_bits_header_src             (o_src[0]),
        .io_out_0_bits_header_dst             (o_dst[0]),
        .io_out_0_bits_payload_addr_beat      (o_beat[0]),
        .io_out_0_bits_payload_addr_block     (o_block[0]),
        .io_out_0_bits_payload_client_xact_id (o_xid[0]),
        .io_out_0_bits_payload_voluntary      (o_vol[0]),
        .io_out_0_bits_payload_r_type         (o_rtype[0]),
        .io_out_0_bits_payload_data           (o_data[0]),
        .io_out_1_valid                       (out_valid[1]),
        .io_out_1_ready                       (rdy[1]),
        .io_out_1_bits_header_src             (o_src[1]),
        .io_out_1_bits_header_dst             (o_dst[1]),
        .io_out_1_bits_payload_addr_beat      (o_beat[1]),
        .io_out_1_bits_payload_addr_block     (o_block[1]),
        .io_out_1_bits_payload_client_xact_id (o_xid[1]),
        .io_out_1_bits_payload_voluntary      (o_vol[1]),
        .io_out_1_bits_payload_r_type         (o_rtype[1]),
        .io_out_1_bits_payload_data           (o_data[1]),
        .io_out_2_valid                       (out_valid[2]),
        .io_out_2_ready                       (rdy[2]),
        .io_out_2_bits_header_src             (o_src[2]),
        .io_out_2_bits_header_dst             (o_dst[2]),
        .io_out_2_bits_payload_addr_beat      (o_beat[2]),
        .io_out_2_bits_payload_addr_block     (o_block[2]),
        .io_out_2_bits_payload_client_xact_id (o_xid[2]),
        .io_out_2_bits_payload_voluntary      (o_vol[2]),
        .io_out_2_bits_payload_r_type         (o_rtype[2]),
        .io_out_2_bits_payload_data           (o_data[2]),
        .io_out_3_valid                       (out_valid[3]),
        .io_out_3_ready                       (rdy[3]),
        .io_out_3_bits_header_src             (o_src[3]),
        .io_out_3_bits_header_dst             (o_dst[3]),
        .io_out_3_bits_payload_addr_beat      (o_beat[3]),
        .io_out_3_bits_payload_addr_block     (o_block[3]),
        .io_out_3_bits_payload_client_xact_id (o_xid[3]),
        .io_out_3_bits_payload_voluntary      (o_vol[3]),
        .io_out_3_bits_payload_r_type         (o_rtype[3]),
        .io_out_3_bits_payload_data           (o_data[3]),
        .io_locked                            (locked),
        .io_dst_err                           (dst_err)
    );

    typedef struct packed {
        logic [1:0]    port;
        logic [BW-1:0] bits;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + reference model: a message is BEATS beats following its first
    // data-carrying beat's destination; everything else goes where its header says.
    initial begin
        int         lock_rem;
        logic [1:0] lock_port;
        logic       m_err;
        logic [3:0] exp_v;
        logic       exp_rdy;
        logic [1:0] p;
        exp_t       f;
        lock_rem  = 0;
        lock_port = 2'd0;
        m_err     = 1'b0;
        f         = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                q.delete();
                lock_rem = 0;
                m_err    = 1'b0;
                check("rst_valid", 128'(out_valid), 128'(0));
                check("rst_locked", 128'(locked), 128'(0));
                check("rst_dst_err", 128'(dst_err), 128'(0));
            end else begin
                exp_v   = 4'b0000;
                exp_rdy = 1'b1;
                if (q.size() > 0) begin
                    f              = q[0];
                    exp_v[f.port]  = 1'b1;
                    exp_rdy        = rdy[f.port];
                end
                check("out_valid", 128'(out_valid), 128'(exp_v));
                check("in_ready", 128'(in_ready), 128'(exp_rdy));
                check("locked", 128'(locked), 128'(lock_rem != 0));
                check("dst_err", 128'(dst_err), 128'(m_err));
                if (q.size() > 0 && rdy[f.port]) begin
                    check("out_bits", 128'(o_bits[f.port]), 128'(f.bits));
                    void'(q.pop_front());
                end
                if (in_valid && in_ready) begin
                    if (lock_rem > 0) begin
                        p = lock_port;
                        if (CHECK && in_dst != lock_port) m_err = 1'b1;
                        lock_rem--;
                    end else begin
                        p = in_dst;
                        if (in_rtype < 3'd3) begin
                            lock_port = in_dst;
                            lock_rem  = BEATS - 1;
                        end
                    end
                    q.push_back('{port: p, bits: in_bits});
                end
            end
        end
    end

    task automatic set_beat(input logic [1:0] dst, input logic [2:0] rtype);
        in_valid = 1'b1;
        in_src   = 2'($urandom);
        in_dst   = dst;
        in_beat  = 3'($urandom);
        in_block = 26'($urandom);
        in_xid   = 1'($urandom);
        in_vol   = 1'($urandom);
        in_rtype = rtype;
        in_data  = {$urandom, $urandom};
    endtask

    task automatic wait_accept();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 50 cycles");
        end
    endtask

    task automatic send(input logic [1:0] dst, input logic [2:0] rtype);
        set_beat(dst, rtype);
        wait_accept();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        in_valid = 1'b0;
        in_src   = '0;
        in_dst   = '0;
        in_beat  = '0;
        in_block = '0;
        in_xid   = '0;
        in_vol   = '0;
        in_rtype = '0;
        in_data  = '0;
        rdy      = 4'hF;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2);

        // Single non-data beat to port 2.
        send(2'd2, 3'd3);
        idle(3);

        // 8-beat data message: first to 1, rest claim 3 but must follow the lock.
        send(2'd1, 3'd0);
        for (int i = 0; i < 7; i++) send(2'd3, 3'd0);
        idle(3);
        check("msg_dst_err", 128'(dst_err), 128'(CHECK));

        // Stalled port 0 for 5 cycles with a second beat waiting.
        rdy = 4'b1110;
        send(2'd0, 3'd3);
        set_beat(2'd1, 3'd4);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rdy = 4'hF;
        wait_accept();
        idle(3);

        // Back-to-back single beats across all ports.
        for (int k = 0; k < 4; k++) send(2'(k), 3'd3);
        idle(3);

        // Reset three beats into a locked message.
        send(2'd2, 3'd1);
        send(2'($urandom), 3'd1);
        send(2'($urandom), 3'd1);
        in_valid = 1'b0;
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(1);
        send(2'd3, 3'd3);
        idle(3);

        // Random traffic with random backpressure.
        repeat (3000) begin
            rdy = 4'($urandom) | 4'($urandom);
            if ($urandom_range(0, 3) != 0) set_beat(2'($urandom), 3'($urandom_range(0, 7)));
            else in_valid = 1'b0;
            @(posedge clk);
            #1;
        end

        rdy = 4'hF;
        idle(5);
        check("drain", 128'(q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/coreriscv_axi4_release_demux.md
CORERISCV_AXI4_RELEASE_DEMUX -- requirements
Module: coreriscv_axi4_release_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 64: payload_data width.
REQ-002 SHALL have parameter BEATS, default 8: beats per data-carrying message; power of two.
REQ-003 SHALL have one clock and asynchronous active-low reset: clk, reset_n.
REQ-004 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port io_in_valid, input, 1: upstream beat valid.
REQ-007 SHALL have port io_in_ready, output, 1: beat accepted when valid&ready.
REQ-008 SHALL have ports io_in_bits_header_src/dst, input, 2 each: source and destination port.
REQ-009 SHALL have ports io_in_bits_payload_addr_beat (3), addr_block (26), client_xact_id (1), voluntary (1), r_type (3) and data (DATA_W), all inputs.
REQ-010 SHALL have per k=0..3: io_out_k_valid (output, 1), io_out_k_ready (input, 1), and io_out_k_bits_* (outputs, widths as io_in_bits_*).
REQ-011 SHALL have port io_locked, output, 1: multi-beat lock active.
REQ-012 SHALL have port io_dst_err, output, 1: sticky lock-destination mismatch flag.

Function
REQ-013 SHALL hold one beat in a single-entry buffer (full flag, stored bits, stored route dst); latency input-accept to output-valid is exactly 1 cycle.
REQ-014 SHALL drive io_out_k_valid = full & (route_dst == k); every io_out_k_bits_* SHALL carry the buffered bits unconditionally.
REQ-015 SHALL pop on io_out_[route_dst]_ready & full; other outputs' ready SHALL be ignored.
REQ-016 SHALL drive io_in_ready = !full | pop; simultaneous push and pop SHALL replace the entry with no bubble.
REQ-017 SHALL classify a beat as data-carrying iff r_type is 0, 1 or 2.
REQ-018 SHALL, in state IDLE (beat count 0), route a pushed beat to header_dst; a pushed data-carrying beat SHALL capture lock_dst = header_dst and increment count.
REQ-019 SHALL, in state LOCKED (count != 0), route every pushed beat to lock_dst irrespective of header_dst and r_type, incrementing count per push.
REQ-020 SHALL wrap count from BEATS-1 to 0 on push, returning to IDLE; io_locked = (count != 0).
REQ-021 SHALL leave count, lock_dst and route unchanged when no push occurs; non-data beats in IDLE SHALL NOT change count.
REQ-022 SHALL never drop, duplicate or reorder beats; a stalled output SHALL backpressure io_in (no head-of-line bypass).

Reset
REQ-023 SHALL, on reset_n low, asynchronously clear full, count, lock_dst, route_dst and io_dst_err to 0; all io_out_k_valid 0, io_locked 0, io_in_ready 1 after release.
REQ-024 SHALL discard any buffered beat and partial lock on reset mid-message.

Configuration
REQ-025 SHALL, with CORERISCV_AXI4_DEMUX_CHECK_EN defined, set io_dst_err on any push in LOCKED whose header_dst != lock_dst, sticky until reset.
REQ-026 SHALL, without CORERISCV_AXI4_DEMUX_CHECK_EN, tie io_dst_err to 0 and omit the comparator and register.

Structure
REQ-027 SHALL place field widths, BEATS default, r_type data-carrying codes and a has_data function in package coreriscv_axi4_release_pkg.
REQ-028 SHALL implement the single-entry buffer as sub-module coreriscv_axi4_release_buf; lock counter and routing remain in the top.

Verification
REQ-029 Single beat r_type=3, dst=2, all readies 1 -> io_out_2_valid next cycle only, io_locked stays 0.
REQ-030 8 beats r_type=0, first dst=1, later beats dst=3 -> all 8 on io_out_1; io_locked 1 after beat 1 through beat 8 push; io_dst_err=1 iff macro defined.
REQ-031 Push dst=0 with io_out_0_ready=0 for 5 cycles -> io_in_ready 0 those cycles, beat held, delivered once on ready.
REQ-032 Back-to-back beats dst=0,1,2,3 with readies 1 -> one output beat per cycle, in order, no bubble.
REQ-033 reset_n low after 3 of 8 locked beats -> valids 0 immediately, io_locked 0; next r_type=3 beat routes by its own dst.
